// File: rtl/imem_load_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imem_load_fetch_ctrl
//  Purpose  : Owns the single port of the instruction memory and shares it
//             between a streaming program loader and the CPU fetch stage.
//             After reset (or a reload pulse) the LOAD phase writes loader
//             words to consecutive addresses while the CPU is stalled; the
//             RUN phase then serves byte-addressed PC fetches, one response
//             per request, with misaligned/out-of-program fetches flagged as
//             faults and answered with NOP_WORD.
//  Ports    : clk, rst_n            - clock / async active-low reset
//             reload                - restart program load (pulse)
//             ld_valid/ld_data/ld_last/ld_ready - loader stream handshake
//             fetch_req/fetch_pc    - CPU fetch request (byte address)
//             fetch_valid/fetch_instr/fetch_fault - fetch response
//             cpu_stall             - CPU must hold while memory is written
//             mem_we/mem_addr/mem_wdata/mem_rdata - memory port (sync read)
//             load_count            - words in the current program
//  Revision : 1.0 - initial release
// ============================================================================
module imem_load_fetch_ctrl #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_wp_max = '1;
    localparam logic [DATA_W-1:0] c_nop    = NOP_WORD[DATA_W-1:0];

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_wp;
    logic [ADDR_W:0]     r_load_count;
    logic                r_rsp_valid;
    logic                r_rsp_fault;
    logic [DATA_W-1:0]   r_hold_instr;
    logic                r_hold_fault;

    logic                w_accept;
    logic                w_fetch;
    logic                w_fault;
    logic [ADDR_W-1:0]   w_idx;
    logic [DATA_W-1:0]   w_instr;

    // Word index of the requested PC and its fault classification.
    assign w_idx   = fetch_pc[ADDR_W+1:2];
    assign w_fault = (fetch_pc[1:0] != 2'b00)
                   || (fetch_pc[31:ADDR_W+2] != '0)
                   || ({1'b0, w_idx} >= r_load_count);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port / handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        ld_ready  = 1'b0;
        cpu_stall = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_accept  = 1'b0;
        w_fetch   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                ld_ready  = 1'b1;
                cpu_stall = 1'b1;
                mem_addr  = r_wp;
                // rst_n gates the write so an asynchronous reset that lands
                // mid-cycle never lets a half-accepted word reach memory.
                // A word arriving with reload is dropped rather than written.
                w_accept  = rst_n && ld_valid && !reload;
                mem_we    = w_accept;
                if (w_accept) begin
                    mem_wdata = ld_data;
                    if (ld_last || (r_wp == c_wp_max)) begin
                        w_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fetch_req) begin
                    mem_addr = w_idx;
                end
                // reload wins over a fetch presented in the same cycle.
                w_fetch = rst_n && fetch_req && !reload;
                if (reload) begin
                    w_next = ST_LOAD;
                end
            end
            default: begin
                w_next = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load pointer, program length and fetch response pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp         <= '0;
            r_load_count <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_fault  <= 1'b0;
            r_hold_instr <= c_nop;
            r_hold_fault <= 1'b0;
        end else begin
            r_rsp_valid <= w_fetch;
            r_rsp_fault <= w_fault;
            if (r_rsp_valid) begin
                r_hold_instr <= w_instr;
                r_hold_fault <= r_rsp_fault;
            end
            if (reload) begin
                r_wp         <= '0;
                r_load_count <= '0;
            end else if (w_accept) begin
                // wp wraps to 0 only on the final word, which also exits LOAD.
                r_wp         <= r_wp + 1'b1;
                r_load_count <= {1'b0, r_wp} + 1'b1;
            end
        end
    end

    // The memory read data is only valid in the response cycle, so the
    // response is formed combinationally then and held in registers after.
    assign w_instr     = r_rsp_fault ? c_nop : mem_rdata;
    assign fetch_valid = r_rsp_valid;
    assign fetch_instr = r_rsp_valid ? w_instr : r_hold_instr;
    assign fetch_fault = r_rsp_valid ? r_rsp_fault : r_hold_fault;
    assign load_count  = r_load_count;

endmodule
`default_nettype wire
